// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment table,
// blank pattern and digit-index width helper.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {a,b,c,d,e,f,g} for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic int seg7_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment lookup.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_mux.sv
// N-digit time-multiplexed seven-segment driver with frame-synchronous loads and PWM brightness.
// Optional leading-zero blanking is built when SEG7_LEADING_ZERO_BLANK_EN is defined.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_WIDTH  = 10,
    parameter int BRIGHT_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    load,
    output logic [7:0]              segments,
    output logic [NUM_DIGITS-1:0]   digits,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int IDX_W = seg7_idx_width(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_WIDTH-1:0]    prescaler;
    logic [IDX_W-1:0]        index;
    logic                    tick;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] stg_value, disp_value;
    logic [NUM_DIGITS-1:0]   stg_dp, disp_dp;
    logic [BRIGHT_W-1:0]     stg_bright, disp_bright;

    logic [BRIGHT_W-1:0]     phase;
    logic                    lit;
    logic [3:0]              nibble;
    logic [6:0]              seg7;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   dig_next;

    assign tick = &prescaler;
    assign wrap = tick && (index == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler   <= '0;
            index       <= '0;
            frame_done  <= 1'b0;
            pending     <= 1'b0;
            stg_value   <= '0;
            stg_dp      <= '0;
            stg_bright  <= '0;
            disp_value  <= '0;
            disp_dp     <= '0;
            disp_bright <= '1;
        end else begin
            prescaler  <= prescaler + DIV_WIDTH'(1);
            frame_done <= wrap;
            if (tick) begin
                index <= wrap ? '0 : index + IDX_W'(1);
            end
            // A load coinciding with wrap stays pending; the older staging goes out now.
            if (wrap && pending) begin
                disp_value  <= stg_value;
                disp_dp     <= stg_dp;
                disp_bright <= stg_bright;
            end
            if (load) begin
                stg_value  <= value;
                stg_dp     <= dp_mask;
                stg_bright <= brightness;
            end
            pending <= load || (pending && !wrap);
        end
    end

    assign phase  = prescaler[DIV_WIDTH-1 -: BRIGHT_W];
    assign lit    = (phase <= disp_bright);
    assign nibble = disp_value[{index, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble (nibble),
        .seg    (seg7)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_blank;

    // Digit i blanks when it and every digit to its left hold zero and its dp is off.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero  = upper_zero && (disp_value[4*i +: 4] == 4'h0);
            lz_blank[i] = upper_zero && !disp_dp[i];
        end
    end
`endif

    always_comb begin
        seg_next = SEG_BLANK;
        dig_next = '1;
        if (lit) begin
            dig_next = ~(NUM_DIGITS'(1) << index);
            seg_next = {seg7, ~disp_dp[index]};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (lz_blank[index]) begin
                seg_next = SEG_BLANK;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            segments <= SEG_BLANK;
            digits   <= '1;
        end else begin
            segments <= seg_next;
            digits   <= dig_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: step-count reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_seg7_scan_mux;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam int ND = 6;
`else
    localparam int ND = 4;
`endif
    localparam int DW    = 4;
    localparam int BW    = 2;
    localparam int SLOT  = 1 << DW;
    localparam int FRAME = SLOT * ND;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [4*ND-1:0] value = '0;
    logic [ND-1:0]   dp_mask = '0;
    logic [BW-1:0]   brightness = '0;
    logic            load = 1'b0;
    logic [7:0]      segments;
    logic [ND-1:0]   digits;
    logic            frame_done;
    logic            pending;

    seg7_scan_mux #(.NUM_DIGITS(ND), .DIV_WIDTH(DW), .BRIGHT_W(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_mask    (dp_mask),
        .brightness (brightness),
        .load       (load),
        .segments   (segments),
        .digits     (digits),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference segment table, independent of the RTL package
    logic [6:0] tab [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    // Model state: s = clock edges since reset release
    int              s;
    logic [4*ND-1:0] m_stg_v, m_disp_v;
    logic [ND-1:0]   m_stg_dp, m_disp_dp;
    logic [BW-1:0]   m_stg_b, m_disp_b;
    logic            m_pend;
    logic [7:0]      exp_seg;
    logic [ND-1:0]   exp_dig;
    logic            exp_fd, exp_pend;
    int              m_p, m_idx, m_ph;
    logic            m_wrap, m_blank;
    logic [3:0]      m_nib;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s = 0;
            m_stg_v = '0; m_disp_v = '0; m_stg_dp = '0; m_disp_dp = '0;
            m_stg_b = '0; m_disp_b = '1; m_pend = 1'b0;
            exp_seg = 8'hFF; exp_dig = '1; exp_fd = 1'b0; exp_pend = 1'b0;
        end else begin
            m_p    = s % SLOT;
            m_idx  = (s / SLOT) % ND;
            m_ph   = m_p / (SLOT >> BW);
            m_wrap = (s % FRAME) == (FRAME - 1);
            m_nib  = m_disp_v[4*m_idx +: 4];
            m_blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            m_blank = (m_idx > 0) && !m_disp_dp[m_idx] && ((m_disp_v >> (4*m_idx)) == 0);
`endif
            if (m_ph <= int'(m_disp_b)) begin
                exp_dig = ~(ND'(1) << m_idx);
                exp_seg = m_blank ? 8'hFF : {tab[m_nib], ~m_disp_dp[m_idx]};
            end else begin
                exp_dig = '1;
                exp_seg = 8'hFF;
            end
            exp_fd = m_wrap;
            if (m_wrap && m_pend) begin
                m_disp_v = m_stg_v; m_disp_dp = m_stg_dp; m_disp_b = m_stg_b;
            end
            if (load) begin
                m_stg_v = value; m_stg_dp = dp_mask; m_stg_b = brightness;
            end
            m_pend   = load || (m_pend && !m_wrap);
            exp_pend = m_pend;
            s++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("segments", segments, exp_seg);
            check("digits", digits, exp_dig);
            check("frame_done", frame_done, exp_fd);
            check("pending", pending, exp_pend);
        end
    end

    function automatic logic [ND-1:0] dig_on(input int k);
        return ~(ND'(1) << k);
    endfunction

    task automatic do_load(input logic [4*ND-1:0] v, input logic [ND-1:0] dp, input logic [BW-1:0] b);
        @(negedge clk);
        value = v; dp_mask = dp; brightness = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("pending_after_load", pending, 1'b1);
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 2*FRAME + 4);
        if (!frame_done) check("frame_done_timeout", 0, 1);
    endtask

    task automatic wait_digit(input int k);
        int n = 0;
        while (digits !== dig_on(k) && n < 2*FRAME + 4) begin
            @(negedge clk);
            n++;
        end
        if (digits !== dig_on(k)) check("digit_wait_timeout", k, 99);
    endtask

    int t0, cnt;
    logic [4*ND-1:0] v;

    initial begin
        #1 rst = 1'b0;
        #2;
        check("reset_segments", segments, 8'hFF);
        check("reset_digits", digits, {ND{1'b1}});
        check("reset_pending", pending, 1'b0);
        check("reset_frame_done", frame_done, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("first_digit", digits, dig_on(0));
        check("first_seg_zero", segments, 8'h03);

        // Reset mid-scan while digit 2 is shown and a load is pending
        do_load('0, '0, 2'd3);
        wait_digit(2);
        #2 rst = 1'b0;
        #1;
        check("midscan_rst_digits", digits, {ND{1'b1}});
        check("midscan_rst_segments", segments, 8'hFF);
        check("midscan_rst_pending", pending, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("restart_digit0", digits, dig_on(0));

        // Scan order and slot/frame timing
        v = '0; v[15:0] = 16'h1234;
        do_load(v, ND'(2), 2'd3);
        wait_fd();
        @(negedge clk);
        check("scan_d0_digits", digits, dig_on(0));
        check("scan_d0_seg", segments, 8'h99);
        cnt = 1;
        while (digits === dig_on(0) && cnt < 40) begin
            @(negedge clk);
            if (digits === dig_on(0)) cnt++;
        end
        check("slot_length", cnt, SLOT);
        check("scan_d1_digits", digits, dig_on(1));
        check("scan_d1_seg", segments, 8'h0C);
        wait_fd(); t0 = cyc;
        wait_fd();
        check("frame_period", cyc - t0, FRAME);

        // Tear-free update
        wait_digit(1);
        v = '0; v[15:0] = 16'hABCD;
        do_load(v, '0, 2'd3);
        wait_digit(2);
        check("tearfree_old_d2", segments, 8'h25);
        wait_fd();
        check("tearfree_pending_clear", pending, 1'b0);
        @(negedge clk);
        check("tearfree_new_d0", segments, 8'h85);

        // Load coincident with wrap
        do_load({ND{4'h1}}, '0, 2'd3);
        cnt = 0;
        while ((s % FRAME) != FRAME - 1 && cnt < 2*FRAME) begin
            @(negedge clk); cnt++;
        end
        value = {ND{4'h5}}; load = 1'b1;
        @(negedge clk); load = 1'b0;
        check("coincident_fd", frame_done, 1'b1);
        check("coincident_pending", pending, 1'b1);
        @(negedge clk);
        check("coincident_shows_1", segments, 8'h9F);
        wait_fd();
        check("coincident_pending_clear", pending, 1'b0);
        @(negedge clk);
        check("coincident_shows_5", segments, 8'h49);

        // Brightness duty
        do_load({ND{4'h8}}, '0, 2'd0);
        wait_fd(); cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (digits !== {ND{1'b1}}) cnt++;
        end
        check("duty_b0", cnt, FRAME / 4);
        do_load({ND{4'h8}}, '0, 2'd3);
        wait_fd(); cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (digits !== {ND{1'b1}}) cnt++;
        end
        check("duty_b3", cnt, FRAME);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        v = '0; v[7:0] = 8'h70;
        do_load(v, '0, 2'd3);
        wait_fd();
        for (int k = 0; k < ND; k++) begin
            wait_digit(k);
            check("lzb_seg", segments, (k == 0) ? 8'h03 : (k == 1) ? 8'h1F : 8'hFF);
        end
`endif

        // Randomized loads at arbitrary times, checked by the model every cycle
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 24) == 0);
            if (load) begin
                for (int k = 0; k < ND; k++) value[4*k +: 4] = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) value = value >> (4 * $urandom_range(1, ND - 1));
                dp_mask    = ND'($urandom);
                brightness = BW'($urandom);
            end
        end
        @(negedge clk); load = 1'b0;
        repeat (FRAME * 2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
